// File: rtl/pkt_pkg.sv
// Frame layout shared by the IQ packetizer and depacketizer: 2 pad bytes, Ethernet,
// IPv4 and UDP headers, a 64-bit sequence number, then 32-bit IQ words.
package pkt_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam int unsigned HDR_BYTES     = 44;
    localparam int unsigned SEQ_BYTES     = 8;
    localparam int unsigned UDP_HDR_BYTES = 8;
    localparam logic [15:0] UDP_OVERHEAD  = 16'(UDP_HDR_BYTES + SEQ_BYTES);

    localparam logic [3:0] W_MAC_LO  = 4'd1;
    localparam logic [3:0] W_ETYPE   = 4'd3;
    localparam logic [3:0] W_IPVER   = 4'd4;
    localparam logic [3:0] W_PROTO   = 4'd6;
    localparam logic [3:0] W_DST_IP  = 4'd8;
    localparam logic [3:0] W_PORTS   = 4'd9;
    localparam logic [3:0] W_UDP_LEN = 4'd10;
    localparam logic [3:0] W_SEQ_LO  = 4'(HDR_BYTES / 4);
    localparam logic [3:0] W_SEQ_HI  = 4'(HDR_BYTES / 4 + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_PAYLOAD,
        ST_TAIL,
        ST_DISCARD
    } rx_state_t;

    // Sequence number travels LSB byte first.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Wire order {I_lo,I_hi,Q_lo,Q_hi} to host order {I,Q}.
    function automatic logic [31:0] iq_swap(input logic [31:0] w);
        return {w[23:16], w[31:24], w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF; synchronous active-low reset.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/udp_iq_depacketizer.sv
// Strips Ethernet/IPv4/UDP headers from MAC RX frames, writes IQ payload to the sample FIFO,
// tracks the 64-bit sequence number and keeps frame statistics.
module udp_iq_depacketizer
    import pkt_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h021234567890,
    parameter logic [31:0] LOCAL_IP   = {8'd192, 8'd168, 8'd50, 8'd50},
    parameter logic [15:0] LOCAL_PORT = 16'd32179,
    parameter int unsigned MAX_IQ     = 367
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rx_data,
    input  logic        rx_dval,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [1:0]  rx_mod,
    input  logic        rx_err,
    output logic        rx_rdy,
    output logic [31:0] out_data,
    output logic        out_wren,
    input  logic        out_full,
    output logic        frame_done,
    output logic        frame_drop,
    output logic        frame_err,
    output logic        seq_gap,
    output logic [63:0] last_seq,
    output logic [15:0] cnt_done,
    output logic [15:0] cnt_drop,
    output logic [15:0] cnt_err,
    output logic [15:0] cnt_gap
);

    localparam int unsigned NW       = $clog2(MAX_IQ + 1);
    localparam logic [13:0] MAX_IQ_W = 14'(MAX_IQ);

    rx_state_t       state, state_nx;
    logic [3:0]      widx, widx_nx;
    logic            mac_hi_local, mac_hi_local_nx;
    logic            mac_hi_bcast, mac_hi_bcast_nx;
    logic [NW-1:0]   n_words, n_words_nx;
    logic [NW-1:0]   pcnt, pcnt_nx;
    logic            ovf, ovf_nx;
    logic [63:0]     seq_r, seq_nx;
    logic [63:0]     exp_seq;
    logic            exp_valid;
    logic [31:0]     data_nx;
    logic            wr_nx, done_nx, drop_nx, err_nx;
    logic            hdr_ok;
    logic            word_whole;
    logic [15:0]     udp_len, iq_bytes;
    logic [13:0]     iq_words;
    logic [NW-1:0]   n_calc;

    assign udp_len    = rx_data[31:16];
    assign iq_bytes   = udp_len - UDP_OVERHEAD;
    assign iq_words   = iq_bytes[15:2];
    assign n_calc     = (iq_words > MAX_IQ_W) ? NW'(MAX_IQ) : NW'(iq_words);
    assign word_whole = !(rx_eop && (rx_mod != 2'd0));

    always_comb begin
        hdr_ok = 1'b1;
        case (widx)
            W_MAC_LO:  hdr_ok = (mac_hi_local && (rx_data == LOCAL_MAC[31:0])) ||
                                (mac_hi_bcast && (rx_data == '1));
            W_ETYPE:   hdr_ok = (rx_data[15:0] == ETHERTYPE_IPV4);
            W_IPVER:   hdr_ok = (rx_data[31:24] == IP_VER_IHL);
            W_PROTO:   hdr_ok = (rx_data[23:16] == IP_PROTO_UDP);
            W_DST_IP:  hdr_ok = (rx_data == LOCAL_IP);
            W_PORTS:   hdr_ok = (rx_data[15:0] == LOCAL_PORT);
            W_UDP_LEN: hdr_ok = (udp_len >= UDP_OVERHEAD);
            default:   hdr_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_nx        = state;
        widx_nx         = widx;
        mac_hi_local_nx = mac_hi_local;
        mac_hi_bcast_nx = mac_hi_bcast;
        n_words_nx      = n_words;
        pcnt_nx         = pcnt;
        ovf_nx          = ovf;
        seq_nx          = seq_r;
        data_nx         = out_data;
        wr_nx           = 1'b0;
        done_nx         = 1'b0;
        drop_nx         = 1'b0;
        err_nx          = 1'b0;
        if (rx_dval && rx_sop) begin
            // A sop always restarts parsing; the interrupted frame is reported by how far it got.
            case (state)
                ST_SEQ, ST_PAYLOAD, ST_TAIL: err_nx  = 1'b1;
                ST_DISCARD:                  drop_nx = 1'b1;
                default: ;
            endcase
            mac_hi_local_nx = (rx_data[15:0] == LOCAL_MAC[47:32]);
            mac_hi_bcast_nx = (rx_data[15:0] == 16'hFFFF);
            widx_nx         = W_MAC_LO;
            pcnt_nx         = '0;
            ovf_nx          = 1'b0;
            if (rx_eop) begin
                drop_nx  = 1'b1;
                state_nx = ST_IDLE;
            end else if (mac_hi_local_nx || mac_hi_bcast_nx) begin
                state_nx = ST_HDR;
            end else begin
                state_nx = ST_DISCARD;
            end
        end else if (rx_dval) begin
            case (state)
                ST_HDR: begin
                    widx_nx = widx + 4'd1;
                    if (rx_eop) begin
                        drop_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (!hdr_ok) begin
                        state_nx = ST_DISCARD;
                    end else if (widx == W_UDP_LEN) begin
                        n_words_nx = n_calc;
                        state_nx   = ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    widx_nx = widx + 4'd1;
                    if (widx == W_SEQ_LO) begin
                        seq_nx[31:0] = bswap32(rx_data);
                        if (rx_eop) begin
                            drop_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        seq_nx[63:32] = bswap32(rx_data);
                        if (rx_eop) begin
                            state_nx = ST_IDLE;
                            if (n_words != '0) drop_nx = 1'b1;
                            else if (rx_err)   err_nx  = 1'b1;
                            else               done_nx = 1'b1;
                        end else begin
                            state_nx = (n_words == '0) ? ST_TAIL : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (word_whole) begin
                        pcnt_nx = pcnt + 1'b1;
                        if (out_full) begin
                            ovf_nx = 1'b1;
                        end else begin
                            wr_nx   = 1'b1;
                            data_nx = iq_swap(rx_data);
                        end
                    end
                    if (rx_eop) begin
                        state_nx = ST_IDLE;
                        if (rx_err || ovf_nx || (pcnt_nx < n_words)) err_nx  = 1'b1;
                        else                                         done_nx = 1'b1;
                    end else if (pcnt_nx == n_words) begin
                        state_nx = ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (rx_eop) begin
                        state_nx = ST_IDLE;
                        if (rx_err || ovf) err_nx  = 1'b1;
                        else               done_nx = 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (rx_eop) begin
                        drop_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            widx         <= '0;
            mac_hi_local <= 1'b0;
            mac_hi_bcast <= 1'b0;
            n_words      <= '0;
            pcnt         <= '0;
            ovf          <= 1'b0;
            seq_r        <= '0;
            exp_seq      <= '0;
            exp_valid    <= 1'b0;
            rx_rdy       <= 1'b0;
            out_data     <= '0;
            out_wren     <= 1'b0;
            frame_done   <= 1'b0;
            frame_drop   <= 1'b0;
            frame_err    <= 1'b0;
            seq_gap      <= 1'b0;
            last_seq     <= '0;
        end else begin
            state        <= state_nx;
            widx         <= widx_nx;
            mac_hi_local <= mac_hi_local_nx;
            mac_hi_bcast <= mac_hi_bcast_nx;
            n_words      <= n_words_nx;
            pcnt         <= pcnt_nx;
            ovf          <= ovf_nx;
            seq_r        <= seq_nx;
            rx_rdy       <= 1'b1;
            out_data     <= data_nx;
            out_wren     <= wr_nx;
            frame_done   <= done_nx;
            frame_drop   <= drop_nx;
            frame_err    <= err_nx;
            seq_gap      <= done_nx && exp_valid && (seq_nx != exp_seq);
            if (done_nx) begin
                last_seq  <= seq_nx;
                exp_seq   <= seq_nx + 64'd1;
                exp_valid <= 1'b1;
            end
        end
    end

    sat_counter16 u_cnt_done (.clk(clk), .reset_n(reset_n), .inc(frame_done), .count(cnt_done));
    sat_counter16 u_cnt_drop (.clk(clk), .reset_n(reset_n), .inc(frame_drop), .count(cnt_drop));
    sat_counter16 u_cnt_err  (.clk(clk), .reset_n(reset_n), .inc(frame_err),  .count(cnt_err));
    sat_counter16 u_cnt_gap  (.clk(clk), .reset_n(reset_n), .inc(seq_gap),    .count(cnt_gap));

endmodule
